// File: rtl/neuro_tick_bank_pkg.sv
// Shared constants for the tick bank: bus bit positions and the
// per-channel config word layout {en, oneshot, period}.
package neuro_pkg;

    localparam int TICK_NEVER_IDX  = 0;
    localparam int TICK_ALWAYS_IDX = 1;
    localparam int TICK_BASE       = 2;
    localparam int PERIOD_LSB      = 0;

    function automatic int cfg_w(input int cnt_w);
        return cnt_w + 2;
    endfunction

    function automatic int en_bit(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int oneshot_bit(input int cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/neuro_tick_chan.sv
// One tick channel: shift stage, shadowed active config, counter,
// one-shot done flag and tick decode.
// Ports: clk, reset, sync_clr, shift_en, shift_in/shift_out, commit,
//        run_en in; tick, done out.
module neuro_tick_chan
    import neuro_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_clr,
    input  logic shift_en,
    input  logic shift_in,
    input  logic commit,
    input  logic run_en,
    output logic shift_out,
    output logic tick,
    output logic done
);

    localparam int CW      = cfg_w(CNT_W);
    localparam int EN_BIT  = en_bit(CNT_W);
    localparam int OS_BIT  = oneshot_bit(CNT_W);

    logic [CW-1:0]    shift_q;
    logic [CW-1:0]    act_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q;

    logic             en;
    logic             oneshot;
    logic [CNT_W-1:0] period;
    logic             at_p;

    assign en      = act_q[EN_BIT];
    assign oneshot = act_q[OS_BIT];
    assign period  = act_q[PERIOD_LSB +: CNT_W];
    assign at_p    = (count_q == period);

    // Shift stage is independent of the running counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_in, shift_q[CW-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q <= '0;
        end else if (commit) begin
            act_q <= shift_q;
        end
    end

    // A one-shot holds its count at P once done; the tick is masked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (sync_clr || commit || !en) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (run_en && !done_q) begin
            if (at_p) begin
                if (oneshot) begin
                    done_q <= 1'b1;
                end else begin
                    count_q <= '0;
                end
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign tick      = en & run_en & ~done_q & at_p;
    assign done      = done_q;
    assign shift_out = shift_q[0];

endmodule

// File: rtl/neuro_tick_bank.sv
// Bank of programmable tick generators with a serial shadowed config
// chain; config commits on the falling edge of config_en.
// Ports: clk, reset, sync_clr, config_en, bs_in, run_en in;
//        bs_out, tick_bus[NUM_CH+1:0], done[NUM_CH-1:0] out.
module neuro_tick_bank
    import neuro_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_clr,
    input  logic              config_en,
    input  logic              bs_in,
    output logic              bs_out,
    input  logic              run_en,
    output logic [NUM_CH+1:0] tick_bus,
    output logic [NUM_CH-1:0] done
);

    logic              config_en_q;
    logic              commit;
    logic [NUM_CH:0]   chain;
    logic [NUM_CH-1:0] ticks;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            config_en_q <= 1'b0;
        end else begin
            config_en_q <= config_en;
        end
    end

    // Commit lands on the first edge that sees config_en low.
    assign commit   = config_en_q & ~config_en;
    assign chain[0] = bs_in;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        neuro_tick_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .sync_clr  (sync_clr),
            .shift_en  (config_en),
            .shift_in  (chain[k]),
            .commit    (commit),
            .run_en    (run_en),
            .shift_out (chain[k+1]),
            .tick      (ticks[k]),
            .done      (done[k])
        );
    end

    assign bs_out = chain[NUM_CH];

    always_comb begin
        tick_bus                     = '0;
        tick_bus[TICK_NEVER_IDX]     = 1'b0;
        tick_bus[TICK_ALWAYS_IDX]    = 1'b1;
        tick_bus[TICK_BASE +: NUM_CH] = ticks;
    end

endmodule

// File: tb/tb_neuro_tick_bank.sv
// Scoreboard bench for neuro_tick_bank against a countdown-based
// behavioural model of the tick channels and the config chain.
module tb_neuro_tick_bank;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 8;
    localparam int CW     = CNT_W + 2;
    localparam int CHAIN  = NUM_CH * CW;

    logic              clk = 1'b1;
    logic              reset;
    logic              sync_clr;
    logic              config_en;
    logic              bs_in;
    logic              run_en;
    logic              bs_out;
    logic [NUM_CH+1:0] tick_bus;
    logic [NUM_CH-1:0] done;

    neuro_tick_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync_clr  (sync_clr),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .run_en    (run_en),
        .tick_bus  (tick_bus),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH+1:0] tb;
        logic [NUM_CH-1:0] dn;
        logic              bo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: chain as a FIFO of bits (front = bs_out side), and per
    // channel the number of run cycles remaining until the next tick.
    bit chain_q[$];
    bit m_en   [NUM_CH];
    bit m_os   [NUM_CH];
    int m_p    [NUM_CH];
    int m_rem  [NUM_CH];
    bit m_done [NUM_CH];
    bit m_cfgq;

    function automatic exp_t model_out();
        exp_t e;
        e    = '0;
        e.tb[1] = 1'b1;
        if (!reset) begin
            e.bo = chain_q[0];
            for (int k = 0; k < NUM_CH; k++) begin
                e.dn[k] = m_done[k];
                e.tb[k+2] = m_en[k] && run_en && !m_done[k]
                            && (m_rem[k] == 0);
            end
        end
        return e;
    endfunction

    task automatic model_clock();
        bit commit;
        int base;
        if (reset) begin
            chain_q = {};
            for (int i = 0; i < CHAIN; i++) chain_q.push_back(1'b0);
            for (int k = 0; k < NUM_CH; k++) begin
                m_en[k] = 0; m_os[k] = 0; m_p[k] = 0;
                m_rem[k] = 0; m_done[k] = 0;
            end
            m_cfgq = 0;
        end else begin
            commit = m_cfgq && !config_en;
            for (int k = 0; k < NUM_CH; k++) begin
                if (commit) begin
                    base = (NUM_CH - 1 - k) * CW;
                    m_p[k] = 0;
                    for (int b = 0; b < CNT_W; b++)
                        m_p[k] += int'(chain_q[base+b]) << b;
                    m_os[k] = chain_q[base+CNT_W];
                    m_en[k] = chain_q[base+CNT_W+1];
                end
                if (commit || sync_clr || !m_en[k]) begin
                    m_rem[k]  = m_p[k];
                    m_done[k] = 0;
                end else if (run_en && !m_done[k]) begin
                    if (m_rem[k] == 0) begin
                        if (m_os[k]) m_done[k] = 1;
                        else m_rem[k] = m_p[k];
                    end else begin
                        m_rem[k]--;
                    end
                end
            end
            if (config_en) begin
                chain_q.push_back(bs_in);
                void'(chain_q.pop_front());
            end
            m_cfgq = config_en;
        end
    endtask

    task automatic step();
        sb.push_back(model_out());
        @(posedge clk);
        model_clock();
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks += 3;
            if (tick_bus !== mon_e.tb) begin
                errors++;
                $display("FAIL tick_bus t=%0t got=%b exp=%b",
                         $time, tick_bus, mon_e.tb);
            end
            if (done !== mon_e.dn) begin
                errors++;
                $display("FAIL done t=%0t got=%b exp=%b",
                         $time, done, mon_e.dn);
            end
            if (bs_out !== mon_e.bo) begin
                errors++;
                $display("FAIL bs_out t=%0t got=%b exp=%b",
                         $time, bs_out, mon_e.bo);
            end
        end
    end

    function automatic logic [CW-1:0] w(bit en, bit os, int p);
        logic [CNT_W-1:0] pp;
        pp = p[CNT_W-1:0];
        return {en, os, pp};
    endfunction

    task automatic shift_words(input logic [CHAIN-1:0] flat,
                               input bit rnd);
        config_en = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            for (int b = 0; b < CW; b++) begin
                bs_in = flat[k*CW+b];
                if (rnd) begin
                    run_en   = ($urandom_range(0, 9) != 0);
                    sync_clr = ($urandom_range(0, 29) == 0);
                end
                step();
            end
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
        sync_clr  = 1'b0;
        step();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                run_en   = ($urandom_range(0, 9) != 0);
                sync_clr = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        sync_clr = 1'b0;
    endtask

    logic [CHAIN-1:0] cfg;
    logic [63:0]      pat;

    initial begin
        reset     = 1'b1;
        sync_clr  = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        run_en    = 1'b0;
        for (int i = 0; i < CHAIN; i++) chain_q.push_back(1'b0);
        @(posedge clk);
        #1;
        step(); step(); step();
        reset  = 1'b0;
        run_en = 1'b1;
        run(20, 0);

        cfg = '0;
        cfg[0*CW +: CW] = w(1, 0, 3);
        shift_words(cfg, 0);
        run(20, 0);

        pat = {$urandom, $urandom};
        config_en = 1'b1;
        for (int i = 0; i < CHAIN; i++) begin
            bs_in = pat[i];
            step();
        end
        bs_in = 1'b0;
        for (int i = 0; i < CHAIN; i++) step();

        cfg = '0;
        cfg[1*CW +: CW] = w(1, 1, 5);
        shift_words(cfg, 0);
        run(55, 0);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        run(15, 0);

        cfg = '0;
        cfg[0*CW +: CW] = w(1, 0, 3);
        shift_words(cfg, 0);
        run(10, 0);
        cfg[0*CW +: CW] = w(1, 0, 1);
        shift_words(cfg, 0);
        run(20, 0);

        cfg = '0;
        cfg[0*CW +: CW] = w(1, 0, 7);
        cfg[2*CW +: CW] = w(1, 0, 0);
        cfg[3*CW +: CW] = w(1, 0, 255);
        shift_words(cfg, 0);
        run(100, 0);
        run_en = 1'b0;
        run(3, 0);
        run_en = 1'b1;
        run(450, 0);

        config_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bs_in = 1'($urandom);
            step();
        end
        reset = 1'b1;
        step(); step();
        reset     = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        run(20, 0);

        for (int r = 0; r < 8; r++) begin
            cfg = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cfg[k*CW +: CW] = w(
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    ($urandom_range(0, 7) == 0) ?
                        int'($urandom_range(0, 255)) :
                        int'($urandom_range(0, 12)));
            end
            shift_words(cfg, 1);
            run(60, 1);
        end
        run_en = 1'b1;
        run(5, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
